// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame-fetch scheduler.
package lcd_pkg;

  localparam int RGB_W = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DATA  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Number of memory words that make up one full frame.
  function automatic int unsigned frame_words(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

endpackage

// File: rtl/lcd_pix_fifo.sv
// Show-ahead pixel FIFO: the head word is visible on head whenever the FIFO
// is non-empty, and reads as 0 when empty. Flush has priority over push/pop.
module lcd_pix_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [RGB_W-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic [RGB_W-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [RGB_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (level != FULL_LVL) && !flush;
  assign do_pop  = pop && (level != '0) && !flush;
  assign head    = (level != '0) ? mem[rd_ptr] : '0;

  // Pointer and occupancy tracking; a flush empties the FIFO outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage write; no reset needed since level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lcd_fetch_sched.sv
// Frame-fetch scheduler: issues fixed-length read bursts from the frame
// buffer into a show-ahead pixel FIFO that feeds lcd_ctrl.
//
// Memory handshake: mem_req rises only when the FIFO has room for a whole
// burst, then mem_req and mem_addr stay constant until mem_ack is sampled
// high with mem_req; after that exactly BURST_LEN mem_rvalid beats follow.
// Only one burst is ever outstanding. The pixel side pops one word on each
// data_req cycle in which the FIFO is non-empty; data_out is the head word.
module lcd_fetch_sched
  import lcd_pkg::*;
#(
  parameter int H_PIXEL    = 800,
  parameter int V_PIXEL    = 480,
  parameter int FIFO_DEPTH = 64,
  parameter int BURST_LEN  = 16,
  parameter int ADDR_W     = 20,
  parameter int BASE_ADDR  = 0
) (
  input  logic                          clk_in,
  input  logic                          sys_rst,
  input  logic                          enable,
  input  logic                          vsync,
  input  logic                          data_req,
  output logic [RGB_W-1:0]              data_out,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ack,
  input  logic                          mem_rvalid,
  input  logic [RGB_W-1:0]              mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  output logic                          frame_done,
  output state_t                        state
);

  localparam int          LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int          BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned TOTAL   = frame_words(H_PIXEL, V_PIXEL);
  localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  BURST_L = LVL_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_ADDR);
  localparam logic [BEAT_W-1:0] LAST_B  = BEAT_W'(BURST_LEN - 1);

  logic              vsync_d;
  logic              frame_start;
  logic              space_ok;
  logic              last_beat;
  logic              push;
  logic              flush;
  logic              discard;
  logic [BEAT_W-1:0] beat_cnt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       words;

  assign frame_start = enable && vsync && !vsync_d;
  assign space_ok    = (DEPTH_L - fifo_level) >= BURST_L;
  assign last_beat   = mem_rvalid && (beat_cnt == LAST_B);
  assign push        = (state == DATA) && mem_rvalid;
  // A frame start empties the FIFO; so does the end of a discarded burst.
  assign flush       = frame_start || ((state == DRAIN) && last_beat);

  lcd_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_in),
    .rst   (sys_rst),
    .push  (push),
    .din   (mem_rdata),
    .pop   (data_req),
    .flush (flush),
    .level (fifo_level),
    .head  (data_out)
  );

  // Registered copy of vsync for rising-edge detection.
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) vsync_d <= 1'b0;
    else         vsync_d <= vsync;
  end

  // Sticky underflow flag; a new frame clears it.
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst)                              underflow <= 1'b0;
    else if (frame_start)                     underflow <= 1'b0;
    else if (data_req && (fifo_level == '0))  underflow <= 1'b1;
  end

  // Burst scheduler FSM with address/word counters and registered outputs.
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      frame_done <= 1'b0;
      discard    <= 1'b0;
      beat_cnt   <= '0;
      addr       <= BASE_L;
      words      <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (frame_start) begin
            addr  <= BASE_L;
            words <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req) begin
            // A restart while the request is pending keeps the request
            // intact but marks its data for discarding.
            if (frame_start) begin
              discard <= 1'b1;
              addr    <= BASE_L;
              words   <= '0;
            end
            if (mem_ack) begin
              mem_req  <= 1'b0;
              beat_cnt <= '0;
              discard  <= 1'b0;
              state    <= (discard || frame_start) ? DRAIN : DATA;
            end
          end else if (frame_start) begin
            addr  <= BASE_L;
            words <= '0;
          end else if (!enable) begin
            state <= IDLE;
          end else if (space_ok) begin
            mem_req  <= 1'b1;
            mem_addr <= addr;
          end
        end
        DATA: begin
          if (mem_rvalid) beat_cnt <= beat_cnt + BEAT_W'(1);
          if (frame_start) begin
            addr  <= BASE_L;
            words <= '0;
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= ISSUE;
            end else begin
              state <= DRAIN;
            end
          end else if (last_beat) begin
            beat_cnt <= '0;
            addr     <= addr + ADDR_W'(BURST_LEN);
            words    <= words + 32'(BURST_LEN);
            if ((words + 32'(BURST_LEN)) == 32'(TOTAL)) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else if (enable) begin
              state <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (mem_rvalid) beat_cnt <= beat_cnt + BEAT_W'(1);
          if (frame_start || last_beat) begin
            addr  <= BASE_L;
            words <= '0;
          end
          if (last_beat) begin
            beat_cnt <= '0;
            state    <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lcd_fetch_sched.md
Name: lcd_fetch_sched

Overview:
- Frame-fetch scheduler that keeps lcd_ctrl's pixel input fed from a burst-read memory port.
- Issues fixed-length read bursts into a show-ahead pixel FIFO and pops one pixel per data_req cycle.
- Restarts the frame address on each vsync rising edge and flags underflow.
- Sits between the frame-buffer read port and lcd_ctrl: data_out drives data_in, and data_req/vsync come from lcd_ctrl.

Parameters:
- H_PIXEL, 800, active pixels per line
- V_PIXEL, 480, active lines per frame
- FIFO_DEPTH, 64, pixel FIFO entries; power of 2, ≥ 2*BURST_LEN
- BURST_LEN, 16, words per read burst; H_PIXEL*V_PIXEL must be a multiple of it
- ADDR_W, 20, word-address width
- BASE_ADDR, 0, frame-buffer start word address

Ports:
- clk_in  in  1  pixel clock, shared with lcd_ctrl
- sys_rst  in  1  asynchronous, active-high reset
- enable  in  1  fetch enable
- vsync  in  1  lcd_ctrl vsync, high during vertical blank
- data_req  in  1  lcd_ctrl pixel request (pop)
- data_out  out  24  FIFO head pixel; 0 when FIFO empty
- mem_req  out  1  burst request, held until mem_ack
- mem_addr  out  ADDR_W  burst start address, stable while mem_req
- mem_ack  in  1  burst accepted
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  24  read beat data
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- underflow  out  1  sticky: data_req while FIFO empty; cleared at frame start
- frame_done  out  1  one-cycle pulse when the last burst of a frame completes

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, address = BASE_ADDR. The vsync edge register resets to 0, so a vsync that is high out of reset produces a frame start on the first cycle.
- Frame start is a vsync rising edge (vsync & ~vsync_d) with enable high:
  - flush FIFO;
  - address = BASE_ADDR, word counter = 0;
  - clear underflow;
  - go to ISSUE.
- States: IDLE, ISSUE, DATA, DRAIN, DONE.
- IDLE: wait for frame start.
- ISSUE:
  - mem_req=1 only when FIFO_DEPTH − fifo_level ≥ BURST_LEN; otherwise mem_req=0 and wait.
  - Once asserted, mem_req and mem_addr hold until mem_ack. mem_ack → DATA.
- DATA:
  - Each mem_rvalid pushes mem_rdata. Count BURST_LEN beats.
  - On the last beat: address += BURST_LEN, words += BURST_LEN.
  - If words == H_PIXEL*V_PIXEL: pulse frame_done and go to DONE.
  - Else if enable: go to ISSUE. Else: go to IDLE.
- DONE: wait for next frame start.
- Only one burst is outstanding at a time. The space check at ISSUE therefore guarantees no overflow.
- Frame start during DATA (or during ISSUE after mem_ack): go to DRAIN.
  - DRAIN discards remaining beats, with no push.
  - After the last beat: flush, reload address, go to ISSUE.
- Frame start during ISSUE before mem_ack: keep mem_req and mem_addr held, and treat the burst as discarded as in DRAIN.
- enable deasserted: the current burst completes normally, then IDLE. No new mem_req is raised.
- FIFO is show-ahead:
  - data_out is the head word the same cycle data_req is sampled (lcd_ctrl uses it combinationally).
  - data_req with level>0 pops.
  - data_req with level==0: no pop, data_out=0, underflow set.
- Simultaneous push and pop: level unchanged; the pushed word goes behind the head.
- Flush on the same cycle as a push or pop: flush wins, level=0.
- Address arithmetic is modulo 2^ADDR_W. No upper-bound check beyond the word count.
- Reset mid-burst: immediate return to the reset state. Outstanding beats after reset are ignored (state IDLE never pushes).

Decomposition:
- lcd_pkg holds the state enum, RGB_W=24, and the frame-word-count function.
- Sub-module lcd_pix_fifo: synchronous show-ahead FIFO with push, pop, flush, level and head output.
- lcd_fetch_sched holds the FSM, vsync edge detect, address/word counters and underflow logic.

Test Plan (H_PIXEL=8, V_PIXEL=4, FIFO_DEPTH=16, BURST_LEN=4, BASE_ADDR=0x100):
- Frame fetch: release reset with vsync=1, memory acks after 2 cycles and returns addr as data → bursts at 0x100,0x104,…,0x11C (8 bursts), frame_done one pulse after last beat, FIFO holds 0x100.. in order.
- Backpressure: no data_req → exactly 4 bursts (level 16) then mem_req stays 0; one data_req pop of 4 → next burst issued at 0x110.
- Underflow: data_req asserted with FIFO empty → data_out=0, underflow=1 held; next vsync rise clears it.
- Mid-burst frame restart: vsync rises after beat 2 of burst at 0x108 → beats 3-4 discarded, level=0, next mem_addr=0x100.
- Simultaneous push/pop at level 5 for 4 cycles → level stays 5, pop order matches push order.
- enable=0 during burst at 0x104 → burst completes (level +4), then IDLE, no further mem_req until enable=1 and next vsync edge.
